// File: rtl/bsg_mul_iterative_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package bsg_mul_iterative_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } bsg_mul_iter_state_e;

    function automatic int bsg_mul_iter_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bsg_mul_iter_step.sv
// One partial-product row: AND the multiplicand with a multiplier bit and add it
// to the running high half, returning the new high half and the bit retired to lo.
module bsg_mul_iter_step
    import bsg_mul_iterative_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0] a_i,
    input  logic               b_bit_i,
    input  logic [width_p-1:0] hi_i,
    output logic [width_p-1:0] hi_o,
    output logic               lsb_o
);

    logic [width_p-1:0] pp_s;
    logic [width_p:0]   sum_s;

    assign pp_s  = a_i & {width_p{b_bit_i}};
    assign sum_s = {1'b0, hi_i} + {1'b0, pp_s};

    // Carry lands in the top bit of hi so no product bit is ever lost.
    assign hi_o  = sum_s[width_p:1];
    assign lsb_o = sum_s[0];

endmodule

// File: rtl/bsg_mul_iterative.sv
// Sequential unsigned multiplier: one shared partial-product row is reused for
// width_p cycles, with valid/ready on the operand side and valid/yumi on the result.
module bsg_mul_iterative
    import bsg_mul_iterative_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 v_i,
    output logic                 ready_o,
    input  logic [width_p-1:0]   a_i,
    input  logic [width_p-1:0]   b_i,
    output logic                 v_o,
    output logic [2*width_p-1:0] result_o,
    input  logic                 yumi_i
);

    localparam int cnt_w_lp = bsg_mul_iter_cnt_width(width_p);

    bsg_mul_iter_state_e state_q;
    logic [width_p-1:0]  a_q;
    logic [width_p-1:0]  b_q;
    logic [width_p-1:0]  hi_q;
    logic [width_p-1:0]  lo_q;
    logic [cnt_w_lp-1:0] cnt_q;
    logic                ready_q;
    logic                v_q;

    logic [width_p-1:0]  step_hi_s;
    logic                step_lsb_s;

    bsg_mul_iter_step #(
        .width_p (width_p)
    ) step_u (
        .a_i     (a_q),
        .b_bit_i (b_q[0]),
        .hi_i    (hi_q),
        .hi_o    (step_hi_s),
        .lsb_o   (step_lsb_s)
    );

    // Control FSM, datapath shift registers and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= {width_p{1'b0}};
            b_q     <= {width_p{1'b0}};
            hi_q    <= {width_p{1'b0}};
            lo_q    <= {width_p{1'b0}};
            cnt_q   <= {cnt_w_lp{1'b0}};
            ready_q <= 1'b1;
            v_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (v_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        hi_q    <= {width_p{1'b0}};
                        lo_q    <= {width_p{1'b0}};
                        cnt_q   <= {cnt_w_lp{1'b0}};
                        ready_q <= 1'b0;
                        state_q <= BUSY;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    hi_q  <= step_hi_s;
                    lo_q  <= {step_lsb_s, lo_q[width_p-1:1]};
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + cnt_w_lp'(1);
                    if (cnt_q == cnt_w_lp'(width_p - 1)) begin
                        v_q     <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                DONE: begin
                    // Result stays frozen in hi/lo until the consumer takes it.
                    if (yumi_i) begin
                        v_q     <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    v_q     <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign v_o      = v_q;
    assign result_o = {hi_q, lo_q};

endmodule

// File: tb/tb_bsg_mul_iterative.sv
// Directed and randomized checks of bsg_mul_iterative at width_p = 16.
module tb_bsg_mul_iterative;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        v_i;
    logic        ready_o;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        v_o;
    logic [31:0] result_o;
    logic        yumi_i;

    int n_checks = 0;
    int n_fail   = 0;
    int n_in_hs  = 0;
    int n_out_hs = 0;

    bsg_mul_iterative #(
        .width_p (16)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .v_o      (v_o),
        .result_o (result_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (rst_ni && v_i && ready_o) n_in_hs++;
        if (rst_ni && v_o && yumi_i)  n_out_hs++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for the result, hold it for hold cycles, then take it.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int hold);
        int lat;
        logic [31:0] first;
        check({tag, "_ready_idle"}, 32'(ready_o), 32'd1);
        a_i = a;
        b_i = b;
        v_i = 1'b1;
        step();
        v_i = 1'b0;
        a_i = 16'($urandom);
        b_i = 16'($urandom);
        check({tag, "_ready_busy"}, 32'(ready_o), 32'd0);
        lat = 0;
        while (!v_o && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd16);
        check({tag, "_ready_done"}, 32'(ready_o), 32'd0);
        check({tag, "_result"}, result_o, exp);
        first = result_o;
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_v"}, 32'(v_o), 32'd1);
            check({tag, "_hold_res"}, result_o, first);
        end
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        check({tag, "_v_after_yumi"}, 32'(v_o), 32'd0);
        check({tag, "_ready_after_yumi"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        int lat;
        int in0;
        int out0;
        logic [15:0] ra;
        logic [15:0] rb;

        rst_ni = 1'b0;
        v_i    = 1'b0;
        yumi_i = 1'b0;
        a_i    = 16'h0000;
        b_i    = 16'h0000;
        step();
        step();
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_v", 32'(v_o), 32'd0);
        check("reset_result", result_o, 32'h0000_0000);
        rst_ni = 1'b1;
        step();
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        check("stray_yumi_ready", 32'(ready_o), 32'd1);
        check("stray_yumi_v", 32'(v_o), 32'd0);

        do_op("basic", 16'd3, 16'd5, 32'h0000_000F, 0);
        do_op("full", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0);
        do_op("msb", 16'h8000, 16'h0002, 32'h0001_0000, 0);
        do_op("zero_a", 16'h0000, 16'h1234, 32'h0000_0000, 0);
        do_op("zero_b", 16'h1234, 16'h0000, 32'h0000_0000, 0);
        do_op("one", 16'h0001, 16'hABCD, 32'h0000_ABCD, 1);

        // Back-pressure with new operands offered during BUSY and DONE.
        a_i = 16'h1234;
        b_i = 16'h0056;
        v_i = 1'b1;
        step();
        a_i = 16'hFFFF;
        b_i = 16'hFFFF;
        lat = 0;
        while (!v_o && lat < 40) begin
            step();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd16);
        check("bp_result", result_o, 32'h0006_1D78);
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_hold_v", 32'(v_o), 32'd1);
            check("bp_hold_res", result_o, 32'h0006_1D78);
        end
        v_i = 1'b0;
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        check("bp_ready", 32'(ready_o), 32'd1);
        step();
        check("bp_no_accept", 32'(ready_o), 32'd1);

        // Reset after seven BUSY steps abandons the operation.
        a_i = 16'h7777;
        b_i = 16'h3333;
        v_i = 1'b1;
        step();
        v_i = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check("midrst_ready", 32'(ready_o), 32'd1);
        check("midrst_v", 32'(v_o), 32'd0);
        check("midrst_result", result_o, 32'h0000_0000);
        step();
        check("midrst_still_idle", 32'(v_o), 32'd0);
        do_op("after_rst", 16'h00FF, 16'h0101, 32'h0000_FFFF, 0);

        in0  = n_in_hs;
        out0 = n_out_hs;
        for (int k = 0; k < 200; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            do_op("rand", ra, rb, 32'(ra) * 32'(rb), int'($urandom_range(0, 5)));
        end
        check("hs_in_count", 32'(n_in_hs - in0), 32'd200);
        check("hs_balance", 32'(n_out_hs - out0), 32'(n_in_hs - in0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
